pipe_reg_chain: RTL and testbench

//  Parametrised DEPTH-stage pipeline register with a per-stage valid bit, valid/ready backpressure and flush.

---
 rtl/pipe_reg_chain_pkg.sv | 22 ++
 rtl/pipe_reg_chain_if.sv | 27 ++
 rtl/pipe_reg_chain_stage.sv | 31 +++
 rtl/pipe_reg_chain.sv | 89 ++++++++
 tb/tb_pipe_reg_chain.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_reg_chain_pkg.sv
// Shared pipeline-register definitions: width/depth defaults, stage record, clog2 helper.
package pipe_reg_chain_pkg;

  localparam int PIPE_WIDTH_DEF = 32;
  localparam int PIPE_DEPTH_MAX = 16;

  // Stage record {valid, data}; the hazard unit uses the same layout when inspecting slots.
  typedef struct packed {
    logic                      valid;
    logic [PIPE_WIDTH_DEF-1:0] data;
  } stage_rec_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if (n > (32'd1 << i)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_reg_chain_if.sv
// Upstream/downstream valid-ready handshake bundle for pipe_reg_chain.
interface pipe_reg_chain_if
  import pipe_reg_chain_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // Environment side: produces input words and consumes output words.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Chain side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pipe_reg_chain_stage.sv
// One pipeline slot: valid bit plus data register, loading from its source when advancing.
module pipe_reg_chain_stage
  import pipe_reg_chain_pkg::*;
#(
  parameter int               WIDTH     = PIPE_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             adv,
  input  logic             src_v,
  input  logic [WIDTH-1:0] src_d,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  // Data only moves with a valid source so bubbles never toggle the payload flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      v <= 1'b0;
      d <= RESET_VAL;
    end else if (flush) begin
      v <= 1'b0;
    end else begin
      if (adv) v <= src_v;
      if (adv && src_v) d <= src_d;
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage valid/ready pipeline register with bubble collapse and flush.
// Optional PIPE_REG_OCC_EN adds a registered occupancy count port.
module pipe_reg_chain
  import pipe_reg_chain_pkg::*;
#(
  parameter int               WIDTH     = PIPE_WIDTH_DEF,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
`ifdef PIPE_REG_OCC_EN
  output logic [clog2(DEPTH+1)-1:0]    occupancy,
`endif
  pipe_reg_chain_if.slave              bus
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("pipe_reg_chain: DEPTH must be >= 1");
  end

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] d [DEPTH];
  logic             in_take;

  // Ready ripples from the output back to stage 0; a local accumulator keeps adv free of self-reads.
  always_comb begin : adv_ripple
    logic acc;
    acc = bus.out_ready;
    adv = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      acc                = !v[DEPTH-1-i] | acc;
      adv[DEPTH-1-i]     = acc;
    end
  end

  always_comb begin
    bus.in_ready  = adv[0] & !flush;
    bus.out_valid = v[DEPTH-1];
    bus.out_data  = d[DEPTH-1];
  end

  assign in_take = bus.in_valid & bus.in_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             src_v;
    logic [WIDTH-1:0] src_d;

    if (k == 0) begin : g_head
      assign src_v = in_take;
      assign src_d = bus.in_data;
    end else begin : g_body
      assign src_v = v[k-1];
      assign src_d = d[k-1];
    end

    pipe_reg_chain_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .adv   (adv[k]),
      .src_v (src_v),
      .src_d (src_d),
      .v     (v[k]),
      .d     (d[k])
    );
  end

`ifdef PIPE_REG_OCC_EN
  logic out_take;
  assign out_take = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occupancy <= '0;
    end else if (in_take && !out_take) begin
      occupancy <= occupancy + 1'b1;
    end else if (!in_take && out_take) begin
      occupancy <= occupancy - 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain (DEPTH=3) against a slot-array/queue reference model.
module tb_pipe_reg_chain;

  localparam int          WIDTH = 32;
  localparam int          DEPTH = 3;
  localparam logic [31:0] RV    = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic flush;

  pipe_reg_chain_if #(.WIDTH(WIDTH)) bus ();

`ifdef PIPE_REG_OCC_EN
  logic [1:0] occupancy;
`endif

  pipe_reg_chain #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (RV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
`ifdef PIPE_REG_OCC_EN
    .occupancy (occupancy),
`endif
    .bus       (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Reference: slot array (index DEPTH-1 is the output) plus in-order queue of accepted words.
  bit          mv [DEPTH];
  logic [31:0] md [DEPTH];
  logic [31:0] sb [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit all_full();
    for (int k = 0; k < DEPTH; k++) if (!mv[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int count_valid();
    int n = 0;
    for (int k = 0; k < DEPTH; k++) if (mv[k]) n++;
    return n;
  endfunction

  // Everything at or behind the output-most hole moves one slot forward; the rest holds.
  task automatic model_update();
    int e;
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        mv[k] = 1'b0;
        md[k] = RV;
      end
      sb.delete();
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) mv[k] = 1'b0;
      sb.delete();
    end else begin
      if (bus.out_ready && mv[DEPTH-1]) mv[DEPTH-1] = 1'b0;
      e = -1;
      for (int k = 0; k < DEPTH; k++) if (!mv[k]) e = k;
      if (e >= 0) begin
        for (int k = e; k > 0; k--) begin
          if (mv[k-1]) md[k] = md[k-1];
          mv[k] = mv[k-1];
        end
        mv[0] = bus.in_valid;
        if (bus.in_valid) begin
          md[0] = bus.in_data;
          sb.push_back(bus.in_data);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("out_valid", bus.out_valid, mv[DEPTH-1]);
        chk("out_data", bus.out_data, md[DEPTH-1]);
        chk("in_ready", bus.in_ready, !flush && (!all_full() || bus.out_ready));
`ifdef PIPE_REG_OCC_EN
        chk("occupancy", occupancy, count_valid());
`endif
        if (mv[DEPTH-1] && bus.out_ready && !reset) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_order: got %0h expected no word (cycle %0d)", bus.out_data, cyc);
          end else if (bus.out_data !== sb[0]) begin
            errors++;
            $display("FAIL sb_order: got %0h expected %0h (cycle %0d)", bus.out_data, sb[0], cyc);
            void'(sb.pop_front());
          end else begin
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic push(input logic [31:0] w);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_w [3];

    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h99;
    bus.out_ready = 1'b0;

    // Reset held two cycles with in_valid asserted.
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, RV);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
`ifdef PIPE_REG_OCC_EN
    chk("rst_occ", occupancy, 0);
`endif

    // Streaming 1..8: word pushed in cycle t appears after three edges.
    bus.out_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      bus.in_valid = (t < 8);
      bus.in_data  = t + 1;
      tick();
      if (t >= 2 && t < 10) begin
        chk("stream_valid", bus.out_valid, 1);
        chk("stream_data", bus.out_data, t - 1);
      end else begin
        chk("stream_idle", bus.out_valid, 0);
      end
    end
    bus.in_valid = 1'b0;

    // Backpressure: fill A,B,C then stall five cycles.
    bus.out_ready = 1'b0;
    push(32'hA);
    push(32'hB);
    push(32'hC);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hD;
    #1;
    chk("bp_in_ready", bus.in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", bus.out_valid, 1);
      chk("bp_hold_data", bus.out_data, 32'hA);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    exp_w[0] = 32'hB;
    exp_w[1] = 32'hC;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bp_drain", bus.out_data, exp_w[i]);
    end
    tick();
    chk("bp_empty", bus.out_valid, 0);

    // Bubble collapse: X at the output, Y at stage 0, hole between.
    bus.out_ready = 1'b0;
    push(32'h77);
    tick();
    tick();
    push(32'h88);
    chk("bub_in_ready", bus.in_ready, 1);
    tick();
    chk("bub_out_hold", bus.out_data, 32'h77);
    push(32'h99);
    chk("bub_full", bus.in_ready, 0);
`ifdef PIPE_REG_OCC_EN
    chk("bub_occ", occupancy, 3);
`endif
    bus.out_ready = 1'b1;
    exp_w[0] = 32'h88;
    exp_w[1] = 32'h99;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bub_drain", bus.out_data, exp_w[i]);
    end
    tick();
    chk("bub_empty", bus.out_valid, 0);

    // Flush with two entries in flight and 0x55 offered.
    bus.out_ready = 1'b0;
    push(32'h11);
    push(32'h22);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h55;
    flush        = 1'b1;
    #1;
    chk("fl_in_ready", bus.in_ready, 0);
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_out_valid", bus.out_valid, 0);
`ifdef PIPE_REG_OCC_EN
    chk("fl_occ", occupancy, 0);
`endif
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fl_no_emerge", bus.out_valid, 0);
    end

    // Mid-stream reset while full and stalled, flush also high.
    bus.out_ready = 1'b0;
    push(32'h101);
    push(32'h102);
    push(32'h103);
    reset        = 1'b1;
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    chk("mr_out_valid", bus.out_valid, 0);
    chk("mr_out_data", bus.out_data, RV);
    reset        = 1'b0;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("mr_in_ready", bus.in_ready, 1);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.in_data   = $urandom;
      bus.out_ready = ($urandom_range(2) != 0);
      flush         = ($urandom_range(39) == 0);
      reset         = ($urandom_range(299) == 0);
      tick();
    end
    reset         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
